// File: rtl/llc_set_wb_pkg.sv
// Shared LLC cache types and constants used by the set write-back engine.
package llc_set_wb_pkg;

    localparam int LLC_WAYS      = 8;
    localparam int LLC_WAY_BITS  = $clog2(LLC_WAYS);
    localparam int LLC_SET_BITS  = 8;
    localparam int LLC_TAG_BITS  = 16;
    localparam int BITS_PER_LINE = 64;
    localparam int STABLE_STATE_BITS = 4;
    localparam int MAX_N_L2      = 16;
    localparam int NL2_BITS      = $clog2(MAX_N_L2);
    localparam int HPROT_WIDTH   = 1;

    typedef logic [LLC_SET_BITS-1:0]      llc_set_t;
    typedef logic [LLC_WAY_BITS-1:0]      llc_way_t;
    typedef logic [LLC_TAG_BITS-1:0]      llc_tag_t;
    typedef logic [BITS_PER_LINE-1:0]     line_t;
    typedef logic [STABLE_STATE_BITS-1:0] llc_state_t;
    typedef logic [MAX_N_L2-1:0]          sharers_t;
    typedef logic [NL2_BITS-1:0]          owner_t;
    typedef logic [HPROT_WIDTH-1:0]       hprot_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAYS,
        ST_EVICT,
        ST_DONE
    } llc_set_wb_state_t;

endpackage

// File: rtl/llc_wb_prio_enc.sv
// Lowest-set-bit priority encoder over a WAYS-wide request vector.
module llc_wb_prio_enc
    import llc_set_wb_pkg::*;
#(
    parameter int WAYS = LLC_WAYS
) (
    input  logic [WAYS-1:0] req,
    output llc_way_t        idx,
    output logic            any
);

    always_comb begin
        idx = '0;
        any = |req;
        // Scan downward so the lowest set bit wins.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (req[i]) idx = llc_way_t'(i);
        end
    end

endmodule

// File: rtl/llc_set_wb.sv
// Writes modified set-buffer ways back to the LLC RAMs, one way per cycle,
// then optionally the evict-way pointer.
module llc_set_wb
    import llc_set_wb_pkg::*;
#(
    parameter int WAYS = LLC_WAYS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  llc_set_t   start_set,
    input  logic [WAYS-1:0] start_mask,
    input  logic       start_evict,
    input  line_t      lines_buf      [WAYS],
    input  llc_tag_t   tags_buf       [WAYS],
    input  llc_state_t states_buf     [WAYS],
    input  sharers_t   sharers_buf    [WAYS],
    input  owner_t     owners_buf     [WAYS],
    input  hprot_t     hprots_buf     [WAYS],
    input  logic       dirty_bits_buf [WAYS],
    input  llc_way_t   evict_way_buf,
    input  logic       ram_ready,
    output logic       wr_en,
    output logic       wr_en_evict_way,
    output llc_set_t   wr_set,
    output llc_way_t   wr_way,
    output line_t      wr_data_line,
    output llc_tag_t   wr_data_tag,
    output llc_state_t wr_data_state,
    output sharers_t   wr_data_sharers,
    output owner_t     wr_data_owner,
    output hprot_t     wr_data_hprot,
    output logic       wr_data_dirty_bit,
    output llc_way_t   wr_data_evict_way,
    output logic       busy,
    output logic       done
);

    llc_set_wb_state_t state_q, state_d;
    llc_set_t          set_q, set_d;
    logic [WAYS-1:0]   mask_q, mask_d;
    logic              evict_q, evict_d;
    llc_way_t          enc_idx;
    logic              enc_any;

    llc_wb_prio_enc #(.WAYS(WAYS)) u_enc (
        .req (mask_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            set_q   <= '0;
            mask_q  <= '0;
            evict_q <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            mask_q  <= mask_d;
            evict_q <= evict_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        set_d             = set_q;
        mask_d            = mask_q;
        evict_d           = evict_q;
        wr_en             = 1'b0;
        wr_en_evict_way   = 1'b0;
        wr_way            = '0;
        wr_data_line      = '0;
        wr_data_tag       = '0;
        wr_data_state     = '0;
        wr_data_sharers   = '0;
        wr_data_owner     = '0;
        wr_data_hprot     = '0;
        wr_data_dirty_bit = 1'b0;
        wr_data_evict_way = '0;
        done              = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    set_d   = start_set;
                    mask_d  = start_mask;
                    evict_d = start_evict;
                    if (|start_mask)     state_d = ST_WAYS;
                    else if (start_evict) state_d = ST_EVICT;
                    else                  state_d = ST_DONE;
                end
            end
            ST_WAYS: begin
                wr_en             = enc_any;
                wr_way            = enc_idx;
                wr_data_line      = lines_buf[enc_idx];
                wr_data_tag       = tags_buf[enc_idx];
                wr_data_state     = states_buf[enc_idx];
                wr_data_sharers   = sharers_buf[enc_idx];
                wr_data_owner     = owners_buf[enc_idx];
                wr_data_hprot     = hprots_buf[enc_idx];
                wr_data_dirty_bit = dirty_bits_buf[enc_idx];
                if (ram_ready) begin
                    // x & (x-1) drops exactly the lowest set bit, i.e. the way just written.
                    mask_d = mask_q & (mask_q - 1'b1);
                    if (mask_d == '0) state_d = evict_q ? ST_EVICT : ST_DONE;
                end
            end
            ST_EVICT: begin
                wr_en_evict_way   = 1'b1;
                wr_data_evict_way = evict_way_buf;
                if (ram_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign wr_set = set_q;

endmodule

// File: doc/llc_set_wb.md
# llc_set_wb

Write-back engine for the LLC set buffers: after a request finishes updating the per-way set buffers, this block writes the modified ways back into the LLC tag/data/state RAMs. It writes one way per cycle and then optionally writes the evict-way pointer. It is the writer-side counterpart of the buffer loader. It sits between the LLC controller FSM, the set buffers and the RAM write ports.

## Interface
Parameters:
- WAYS, default `LLC_WAYS: number of ways; must be a power of two, 2 or more.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous and active-high (this block differs from the rest of the LLC here).
- start  in  1  single-cycle request to begin a write-back.
- start_set  in  llc_set_t  target set; captured when start is accepted.
- start_mask  in  WAYS  bit i set means way i is modified; captured when start is accepted.
- start_evict  in  1  also write the evict-way pointer; captured when start is accepted.
- lines_buf, tags_buf, states_buf, sharers_buf, owners_buf, hprots_buf, dirty_bits_buf  in  [WAYS] arrays of line_t, llc_tag_t, llc_state_t, sharers_t, owner_t, hprot_t, logic  set buffers; must stay stable while busy.
- evict_way_buf  in  llc_way_t  evict pointer to write.
- ram_ready  in  1  the RAM write port accepts the current write this cycle.
- wr_en  out  1  way write valid.
- wr_en_evict_way  out  1  evict-pointer write valid.
- wr_set  out  llc_set_t  target set.
- wr_way  out  llc_way_t  target way.
- wr_data_line, wr_data_tag, wr_data_state, wr_data_sharers, wr_data_owner, wr_data_hprot, wr_data_dirty_bit, wr_data_evict_way  out  field types  write data.
- busy  out  1  the block is not in IDLE.
- done  out  1  single-cycle completion pulse.

## Operation
- State machine has four states: IDLE, WAYS, EVICT, DONE.
- IDLE:
  - A start pulse captures start_set, start_mask (into a pending-mask register) and start_evict.
  - Next state is WAYS if the mask is nonzero, otherwise EVICT if start_evict is set, otherwise DONE.
- WAYS:
  - wr_way is the lowest set bit of the pending mask (priority encoder).
  - wr_en is high, and all wr_data_* outputs are the buffer entries at index wr_way, driven combinationally.
  - When wr_en && ram_ready, that bit is cleared in the pending mask.
  - When the last bit clears, next state is EVICT if the captured evict flag is set, otherwise DONE.
  - Unmodified ways cost no cycles.
- EVICT:
  - wr_en_evict_way is high and wr_data_evict_way equals evict_way_buf.
  - When ram_ready is high, next state is DONE.
- DONE: done is high for exactly one cycle; next state is IDLE.
- busy is high in every state except IDLE.
- wr_set holds the captured set while busy.
- wr_en and wr_en_evict_way are never high in the same cycle.

## Timing
- Reset values: state is IDLE, and every output is 0 (including wr_set, wr_way and all wr_data_*). Pending mask and evict flag are 0.
- Reset asserted mid-operation aborts immediately. No further write is issued, and done is not pulsed.
- Latency: start accepted in cycle 0 means the first write is presented in cycle 1.
  - With N modified ways, evict requested, and ram_ready held high: the evict write is in cycle N+1 and done is in cycle N+2.
  - With an empty mask and no evict, done is in cycle 1.
- Handshake: a write is accepted on a cycle where its enable and ram_ready are both high.
  - While ram_ready is low, wr_en, wr_way, wr_set and wr_data_* hold stable.
- start while busy (including in DONE) is ignored and not queued.
- A start in the same cycle as a rst deassertion edge is not guaranteed to be accepted.
- Outside IDLE, wr_data_* is a don't-care whenever wr_en is low. In IDLE, outputs read 0 after reset and are not required to hold values afterwards.

## Structure
- llc_set_t, llc_way_t and the field types come from the shared cache types header; WAYS defaults to `LLC_WAYS from the shared constants header.
- A state enum, llc_set_wb_state_t, is added to the shared package.
- Sub-module llc_wb_prio_enc: a parameterized lowest-set-bit encoder (WAYS-bit input, llc_way_t index output, any output), also usable by eviction logic.

## Test plan
- WAYS=8, start with mask 8'b1010_0100, evict=0, ram_ready=1 -> writes to ways 2, 5, 7 in cycles 1-3; done in cycle 4; busy high in cycles 1-4.
- Mask 0, evict=1, evict_way_buf=3 -> wr_en_evict_way with data 3 in cycle 1; done in cycle 2; wr_en never high.
- Mask 8'b0000_0011 with ram_ready low in cycles 1-3 -> way 0 held stable through cycle 4; way 1 in cycle 5; done in cycle 6.
- start pulsed again in cycle 2 of a 3-way write-back -> ignored; exactly 3 writes and one done.
- rst raised in cycle 2 of a 4-way write-back -> all outputs 0 asynchronously, state IDLE, no done pulse; a fresh start after reset completes normally.
- Mask 0, evict=0 -> done in cycle 1, with no writes.
